// File: rtl/slice_arbiter.sv
// slice_arbiter: round-robin time-slice arbiter for NREQ requesters.
// Requests are debounced for DEB cycles. A grant lasts at most SLICE cycles.
// Each grant is followed by one dead cycle before the next grant.
module slice_arbiter #(
  parameter  int unsigned NREQ  = 4,
  parameter  int unsigned SLICE = 10,
  parameter  int unsigned DEB   = 3,
  localparam int unsigned IDW   = $clog2(NREQ),
  localparam int unsigned SW    = $clog2(SLICE) + 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            busy,
  output logic [SW-1:0]   slot_cnt,
  output logic            slice_done
);

  localparam int unsigned     DW        = (DEB > 1) ? $clog2(DEB) : 1;
  localparam logic [DW-1:0]   DMAX      = DW'(DEB - 1);
  localparam logic [SW-1:0]   SLOT_LAST = SW'(SLICE - 1);
  localparam logic [IDW-1:0]  LAST_RST  = IDW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [DW-1:0]   dcnt_q [NREQ];
  logic [DW-1:0]   dcnt_d [NREQ];
  logic [NREQ-1:0] qual;
  logic            found;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  cand;

  // Debounce: count consecutive high cycles per requester, saturating at DEB-1
  always_comb begin
    qual = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      dcnt_d[i] = dcnt_q[i];
      if (!req[i])
        dcnt_d[i] = '0;
      else if (dcnt_q[i] != DMAX)
        dcnt_d[i] = dcnt_q[i] + 1'b1;
      qual[i] = req[i] && (dcnt_q[i] == DMAX);
    end
  end

  // Round-robin pick: first qualified index after the last owner, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(last_q) + k) % NREQ);
      if (!found && qual[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Next-state and next-output computation for the IDLE/GRANT/GAP controller
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    slot_d  = slot_q;
    unique case (state_q)
      GRANT: begin
        if (!req[owner_q] || (slot_q == SLOT_LAST)) begin
          state_d = GAP;
          last_d  = owner_q;
          owner_d = '0;
          slot_d  = '0;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      default: begin
        slot_d = '0;
        if (found) begin
          state_d = GRANT;
          owner_d = win;
        end else begin
          state_d = IDLE;
          owner_d = '0;
        end
      end
    endcase
    gnt_d = '0;
    if (state_d == GRANT)
      gnt_d[owner_d] = 1'b1;
  end

  // State, pointer, slot counter, grant and debounce registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      slot_q  <= '0;
      gnt_q   <= '0;
      for (int unsigned i = 0; i < NREQ; i++)
        dcnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      slot_q  <= slot_d;
      gnt_q   <= gnt_d;
      for (int unsigned i = 0; i < NREQ; i++)
        dcnt_q[i] <= dcnt_d[i];
    end
  end

  assign gnt        = gnt_q;
  assign gnt_id     = owner_q;
  assign busy       = |gnt_q;
  assign slot_cnt   = slot_q;
  // The owner releasing in the final slot cycle counts as an early release, so req is examined here
  assign slice_done = (state_q == GRANT) && (slot_q == SLOT_LAST) && req[owner_q];

endmodule

// File: tb/tb_slice_arbiter.sv
// tb_slice_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural model.
module tb_slice_arbiter;

  localparam int NREQ  = 4;
  localparam int SLICE = 10;
  localparam int DEB   = 3;
  localparam int IDW   = $clog2(NREQ);
  localparam int SW    = $clog2(SLICE) + 1;

  logic            clk  = 1'b0;
  logic            rstn = 1'b0;
  logic [NREQ-1:0] req  = '0;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            busy;
  logic [SW-1:0]   slot_cnt;
  logic            slice_done;

  int unsigned total  = 0;
  int unsigned passed = 0;

  slice_arbiter #(.NREQ(NREQ), .SLICE(SLICE), .DEB(DEB)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .busy       (busy),
    .slot_cnt   (slot_cnt),
    .slice_done (slice_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  // Behavioural model: owner index (-1 = none), cycles used, last owner,
  // and unbounded run lengths of consecutive high req cycles.
  int m_owner = -1;
  int m_used  = 0;
  int m_last  = NREQ - 1;
  int m_run [NREQ];

  function automatic void m_reset();
    m_owner = -1;
    m_used  = 0;
    m_last  = NREQ - 1;
    for (int i = 0; i < NREQ; i++) m_run[i] = 0;
  endfunction

  initial m_reset();

  always @(posedge clk or negedge rstn) begin : model
    int nxt;
    if (!rstn) begin
      m_reset();
    end else begin
      nxt = -1;
      if (m_owner >= 0) begin
        if (!req[m_owner] || m_used == SLICE - 1) begin
          m_last  = m_owner;
          m_owner = -1;
        end else begin
          m_used++;
        end
      end else begin
        for (int k = 1; k <= NREQ; k++) begin
          int j;
          j = (m_last + k) % NREQ;
          if (nxt < 0 && req[j] && m_run[j] + 1 >= DEB) nxt = j;
        end
        if (nxt >= 0) begin
          m_owner = nxt;
          m_used  = 0;
        end
      end
      for (int i = 0; i < NREQ; i++) m_run[i] = req[i] ? m_run[i] + 1 : 0;
    end
  end

  // Per-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin : compare
    logic [NREQ-1:0] eg;
    if (rstn) begin
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      chk("gnt", gnt, eg);
      chk("gnt_id", gnt_id, (m_owner >= 0) ? m_owner : 0);
      chk("busy", busy, m_owner >= 0);
      chk("slot_cnt", slot_cnt, (m_owner >= 0) ? m_used : 0);
      chk("slice_done", slice_done, (m_owner >= 0) && m_used == SLICE - 1 && req[m_owner]);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rstn = 1'b0;
    next_cycle();
    rstn = 1'b1;
  endtask

  initial begin
    // Reset with random requests, then release with req idle
    req = NREQ'($urandom);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_slot", slot_cnt, 0);
    chk("rst_done", slice_done, 0);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      req = NREQ'($urandom);
      #3;
      chk("rst_hold_gnt", gnt, 0);
      chk("rst_hold_id", gnt_id, 0);
    end
    next_cycle();
    req  = '0;
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #3;
      chk("post_rst_gnt", gnt, 0);
      chk("post_rst_busy", busy, 0);
      next_cycle();
    end

    // Single requester 2 held: full slice, gap, regrant
    req = 4'b0100;
    for (int k = 0; k < 25; k++) begin
      #3;
      if (k == 2) chk("s2_latency_gnt", gnt, 0);
      if (k == 3) begin
        chk("s2_first_gnt", gnt, 4'b0100);
        chk("s2_first_id", gnt_id, 2);
        chk("s2_first_slot", slot_cnt, 0);
      end
      if (k == 12) begin
        chk("s2_last_gnt", gnt, 4'b0100);
        chk("s2_last_slot", slot_cnt, 9);
        chk("s2_slice_done", slice_done, 1);
      end
      if (k == 11) chk("s2_no_early_done", slice_done, 0);
      if (k == 13) begin
        chk("s2_gap_gnt", gnt, 0);
        chk("s2_gap_busy", busy, 0);
      end
      if (k == 14) begin
        chk("s2_regrant_gnt", gnt, 4'b0100);
        chk("s2_regrant_slot", slot_cnt, 0);
      end
      if (k == 23) chk("s2_regrant_done", slice_done, 1);
      next_cycle();
    end
    req = '0;
    repeat (4) next_cycle();

    // Short pulses on req[1] never qualify
    for (int k = 0; k < 15; k++) begin
      req = (k % 3 < 2) ? 4'b0010 : 4'b0000;
      #3;
      chk("s3_bounce_gnt", gnt, 0);
      next_cycle();
    end

    // All four requesting: rotation 0,1,2,3,0 with a single gap between grants
    reset_pulse();
    req = 4'b1111;
    for (int k = 0; k < 58; k++) begin
      logic [NREQ-1:0] eg;
      #3;
      eg = '0;
      if (k >= 3 && (k - 3) % 11 < 10) eg[((k - 3) / 11) % NREQ] = 1'b1;
      chk("s4_rotation_gnt", gnt, eg);
      next_cycle();
    end

    // Requester 0 releases early at slot 4; requester 1 follows after a gap
    reset_pulse();
    req = 4'b0011;
    for (int k = 0; k < 12; k++) begin
      if (k == 7) req = 4'b0010;
      #3;
      if (k == 7) begin
        chk("s5_drop_gnt", gnt, 4'b0001);
        chk("s5_drop_slot", slot_cnt, 4);
        chk("s5_drop_done", slice_done, 0);
      end
      if (k == 8) chk("s5_gap_gnt", gnt, 0);
      if (k == 9) begin
        chk("s5_next_gnt", gnt, 4'b0010);
        chk("s5_next_id", gnt_id, 1);
        chk("s5_next_slot", slot_cnt, 0);
      end
      if (k == 10) chk("s5_next_slot1", slot_cnt, 1);
      next_cycle();
    end

    // Asynchronous reset in the middle of owner 2's slice
    reset_pulse();
    req = 4'b1111;
    for (int k = 0; k < 32; k++) begin
      #3;
      if (k == 31) begin
        chk("s6_pre_gnt", gnt, 4'b0100);
        chk("s6_pre_slot", slot_cnt, 6);
      end
      if (k < 31) next_cycle();
    end
    rstn = 1'b0;
    #1;
    chk("s6_async_gnt", gnt, 0);
    chk("s6_async_busy", busy, 0);
    chk("s6_async_slot", slot_cnt, 0);
    chk("s6_async_id", gnt_id, 0);
    next_cycle();
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #3;
      chk("s6_after_gnt", gnt, (k >= 3) ? 4'b0001 : 4'b0000);
      next_cycle();
    end

    // Randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 15) == 0) req[i] = ~req[i];
      if ($urandom_range(0, 499) == 0) begin
        #2;
        rstn = 1'b0;
        next_cycle();
        rstn = 1'b1;
      end else begin
        next_cycle();
      end
    end

    req = '0;
    repeat (5) next_cycle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
